// File: rtl/mux_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the stream-mux select scheduler:
//   - sched_state_t : scheduler FSM states
//   - SEL_WIDTH     : default width of the mux select bus
// -----------------------------------------------------------------------------
package mux_sched_pkg;

  localparam int SEL_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HOLD    = 3'd2,
    SWITCH  = 3'd3,
    LINKRST = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_next_channel.sv
// -----------------------------------------------------------------------------
// rr_next_channel
// Purely combinational channel picker for the round-robin scheduler.
// Ports:
//   cur_sel      in  SEL_WIDTH  currently selected channel
//   channel_mask in  N_INPUTS   eligible channels
//   next_sel     out SEL_WIDTH  lowest set bit strictly above cur_sel,
//                               wrapping to the lowest set bit
//   lowest_sel   out SEL_WIDTH  lowest set bit of channel_mask
//   mask_empty   out 1          no channel eligible
// With a single set bit, next_sel equals that bit (the channel reselects
// itself). Outputs are 0 when the mask is empty.
// -----------------------------------------------------------------------------
module rr_next_channel
  import mux_sched_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int SEL_WIDTH = mux_sched_pkg::SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] cur_sel,
  input  logic [N_INPUTS-1:0]  channel_mask,
  output logic [SEL_WIDTH-1:0] next_sel,
  output logic [SEL_WIDTH-1:0] lowest_sel,
  output logic                 mask_empty
);

  // Eligible channels strictly above the current one.
  logic [N_INPUTS-1:0] above_mask;

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_above
      assign above_mask[gi] = channel_mask[gi] && (32'(gi) > 32'(cur_sel));
    end
  endgenerate

  logic [SEL_WIDTH-1:0] above_sel;

  // Scan downwards so the last hit is the lowest set bit.
  always_comb begin
    lowest_sel = '0;
    above_sel  = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (channel_mask[i]) lowest_sel = SEL_WIDTH'(i);
      if (above_mask[i])   above_sel  = SEL_WIDTH'(i);
    end
  end

  assign mask_empty = (channel_mask == '0);
  assign next_sel   = (above_mask != '0) ? above_sel : lowest_sel;

endmodule

// File: rtl/mux_select_scheduler.sv
// -----------------------------------------------------------------------------
// mux_select_scheduler
// Drives output_select of the 16-input stream data mux. Fixed mode holds one
// channel; round-robin mode rotates through channel_mask, dwelling
// dwell_orbits orbits per channel. Channel changes happen only at orbit
// boundaries and never while the mux output is stalled mid-beat.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   enable           run; 0 forces IDLE (select holds, select_valid = 0)
//   rr_mode          1 = round-robin, 0 = fixed
//   fixed_select     channel for fixed mode (>= N_INPUTS clamps to 0)
//   channel_mask     round-robin eligibility mask
//   dwell_orbits     orbits per channel, 0 behaves as 1
//   fc_orbitSync     single-cycle orbit marker
//   fc_linkReset     link reset; parks the scheduler until released
//   out_tvalid/ready mux output handshake (monitor only)
//   output_select    select to the mux
//   select_valid     output_select is actively scheduled
//   switch_pending   boundary reached, waiting for the bus to unstall
//   switch_count     completed switches (wraps)
// -----------------------------------------------------------------------------
module mux_select_scheduler
  import mux_sched_pkg::*;
#(
  parameter int N_INPUTS        = 16,
  parameter int SEL_WIDTH       = mux_sched_pkg::SEL_WIDTH,
  parameter int ORBIT_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       rr_mode,
  input  logic [SEL_WIDTH-1:0]       fixed_select,
  input  logic [N_INPUTS-1:0]        channel_mask,
  input  logic [ORBIT_CNT_WIDTH-1:0] dwell_orbits,
  input  logic                       fc_orbitSync,
  input  logic                       fc_linkReset,
  input  logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [SEL_WIDTH-1:0]       output_select,
  output logic                       select_valid,
  output logic                       switch_pending,
  output logic [ORBIT_CNT_WIDTH-1:0] switch_count
);

  sched_state_t               state_reg,   state_next;
  logic [SEL_WIDTH-1:0]       sel_reg,     sel_next;
  logic                       valid_reg,   valid_next;
  logic                       pending_reg, pending_next;
  logic [ORBIT_CNT_WIDTH-1:0] count_reg,   count_next;
  logic [ORBIT_CNT_WIDTH-1:0] dwell_reg,   dwell_next;

  logic                       stall;
  logic [SEL_WIDTH-1:0]       fixed_clamped;
  logic [SEL_WIDTH-1:0]       rr_next_sel;
  logic [SEL_WIDTH-1:0]       rr_lowest_sel;
  logic                       mask_empty;
  logic                       cur_bit;
  logic [ORBIT_CNT_WIDTH-1:0] dwell_inc;
  logic [ORBIT_CNT_WIDTH-1:0] dwell_lim;

  assign stall         = out_tvalid & ~out_tready;
  assign fixed_clamped = (32'(fixed_select) >= 32'(N_INPUTS)) ? '0 : fixed_select;
  // Whether the channel currently on air is still in the mask.
  assign cur_bit       = |(channel_mask & (N_INPUTS'(1) << sel_reg));
  assign dwell_inc     = dwell_reg + 1'b1;
  assign dwell_lim     = (dwell_orbits == '0) ? ORBIT_CNT_WIDTH'(1) : dwell_orbits;

  rr_next_channel #(
    .N_INPUTS  (N_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_next (
    .cur_sel      (sel_reg),
    .channel_mask (channel_mask),
    .next_sel     (rr_next_sel),
    .lowest_sel   (rr_lowest_sel),
    .mask_empty   (mask_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      valid_reg   <= 1'b0;
      pending_reg <= 1'b0;
      count_reg   <= '0;
      dwell_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
      dwell_reg   <= dwell_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    pending_next = pending_reg;
    count_next   = count_reg;
    dwell_next   = dwell_reg;

    if (!enable) begin
      state_next   = IDLE;
      pending_next = 1'b0;
    end else if (fc_linkReset) begin
      // Link reset outranks a coincident orbit marker.
      state_next   = LINKRST;
      dwell_next   = '0;
      pending_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE, LINKRST: state_next = LOAD;

        LOAD: begin
          if (rr_mode && mask_empty) begin
            sel_next = '0;
          end else begin
            sel_next   = rr_mode ? rr_lowest_sel : fixed_clamped;
            state_next = HOLD;
            dwell_next = '0;
          end
        end

        HOLD: begin
          if (fc_orbitSync) begin
            dwell_next = dwell_inc;
            if (rr_mode) begin
              // >= so that lowering dwell_orbits mid-dwell still moves on.
              if ((dwell_inc >= dwell_lim) || !cur_bit) state_next = SWITCH;
            end else if (fixed_clamped != sel_reg) begin
              state_next = SWITCH;
            end
          end
        end

        SWITCH: begin
          if (stall) begin
            pending_next = 1'b1;
          end else begin
            pending_next = 1'b0;
            if (rr_mode && mask_empty) begin
              state_next = LOAD;
            end else begin
              sel_next   = rr_mode ? rr_next_sel : fixed_clamped;
              state_next = HOLD;
              dwell_next = '0;
              count_next = count_reg + 1'b1;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end

    // Registered alongside the state so it tracks HOLD/SWITCH exactly.
    valid_next = (state_next == HOLD) || (state_next == SWITCH);
  end

  assign output_select  = sel_reg;
  assign select_valid   = valid_reg;
  assign switch_pending = pending_reg;
  assign switch_count   = count_reg;

endmodule

// File: doc/mux_select_scheduler.md
Name: mux_select_scheduler

Overview:
- Sequences the output_select of the 16-input stream data mux so the readout path time-shares the enabled links without software intervention.
- Supports two modes:
  - Fixed mode: holds one channel.
  - Round-robin mode: rotates through a channel mask, dwelling a programmed number of orbits per channel.
- Switches only at orbit boundaries, and only when the mux output is not stalled mid-beat.
- Sits between the IPIF parameter block and the data mux select input, in the mux's clk domain.

Parameters:
- N_INPUTS, 16, number of mux inputs considered (1..16)
- SEL_WIDTH, 4, width of output_select
- ORBIT_CNT_WIDTH, 16, width of dwell and orbit counters

Ports:
- clk  in  1  mux/IP clock; one clock; reset is asynchronous and active-low
- resetn  in  1  asynchronous active-low reset
- enable  in  1  scheduler run; 0 forces the IDLE state
- rr_mode  in  1  1 = round-robin, 0 = fixed
- fixed_select  in  SEL_WIDTH  channel used in fixed mode
- channel_mask  in  N_INPUTS  bit i = channel i eligible in round-robin
- dwell_orbits  in  ORBIT_CNT_WIDTH  orbits per channel; 0 treated as 1
- fc_orbitSync  in  1  single-cycle orbit marker
- fc_linkReset  in  1  link reset (ROCd OR ROCt)
- out_tvalid  in  1  mux output tvalid (monitor)
- out_tready  in  1  mux output tready (monitor)
- output_select  out  SEL_WIDTH  select driven to the mux
- select_valid  out  1  1 when output_select is being actively scheduled
- switch_pending  out  1  boundary reached, waiting for the bus to unstall
- switch_count  out  ORBIT_CNT_WIDTH  number of completed switches; wraps

Behaviour:
- Reset values:
  - output_select = 0, select_valid = 0, switch_pending = 0, switch_count = 0.
  - Internal dwell counter = 0; state = IDLE.
- stall = out_tvalid & ~out_tready. A switch is never allowed while stall = 1.
- Any state, enable = 0: go to IDLE next cycle. output_select holds its last value; select_valid = 0.
- IDLE:
  - On enable = 1 go to LOAD next cycle.
- LOAD:
  - Fixed mode: output_select <= fixed_select.
  - Round-robin mode: output_select <= lowest set bit of channel_mask.
  - Empty mask: output_select <= 0 and select_valid stays 0 (stay in LOAD).
  - Otherwise go to HOLD with dwell = 0 and select_valid = 1.
- HOLD:
  - Each fc_orbitSync increments dwell.
  - Fixed mode:
    - Channel changes only on an fc_orbitSync where fixed_select differs from output_select.
    - That event goes to SWITCH.
  - Round-robin mode:
    - When fc_orbitSync brings dwell to max(dwell_orbits, 1), go to SWITCH.
    - If output_select's mask bit is cleared, go to SWITCH on the next fc_orbitSync regardless of dwell.
- SWITCH:
  - If stall = 1: switch_pending = 1; stay in SWITCH.
  - If stall = 0: update output_select in the same cycle and go to HOLD with dwell = 0.
    - Fixed mode: output_select = fixed_select.
    - Round-robin mode: next set mask bit strictly above the current channel, wrapping to the lowest set bit.
    - Only one set bit: the channel reselects itself.
    - Empty mask: go to LOAD.
    - switch_count increments (wraps at 2^ORBIT_CNT_WIDTH); switch_pending clears.
  - Latency: with no stall, the new select is registered 2 cycles after the fc_orbitSync cycle.
- LINKRST (entered from any enabled state when fc_linkReset = 1):
  - select_valid = 0; dwell = 0.
  - On fc_linkReset deassert, go to LOAD.
  - fc_linkReset has priority over a simultaneous fc_orbitSync.
- Only channels below N_INPUTS are eligible: mask bits ≥ N_INPUTS are ignored, and fixed_select ≥ N_INPUTS is clamped to 0.
- Mid-operation changes:
  - Asynchronous reset in any state returns all outputs to reset values immediately.
  - rr_mode change during HOLD takes effect at the next switch.

Decomposition:
- Package mux_sched_pkg:
  - state enum {IDLE, LOAD, HOLD, SWITCH, LINKRST}.
  - SEL_WIDTH constant.
- Sub-module rr_next_channel: combinational function (current select, mask) → next set bit with wrap, plus a mask-empty flag; used in both LOAD and SWITCH.

Test Plan:
- Fixed mode, fixed_select = 5, enable → output_select = 5 and select_valid = 1 within 2 cycles; unchanged across 10 orbits; switch_count = 0.
- Round-robin, mask = 0x0025, dwell_orbits = 2, 8 orbitSyncs → select sequence 0,2,5,0,2; switch_count = 4.
- Round-robin, mask = 0x0003, stall held 5 cycles at boundary → switch_pending = 1 for 5 cycles; select changes on the first stall-free cycle.
- fc_linkReset asserted coincident with fc_orbitSync in HOLD → select_valid = 0 and no switch; on release, select = lowest mask bit and dwell restarts.
- Round-robin, mask = 0 → select_valid stays 0 and output_select = 0; then mask = 0x8000 → select = 15 and select_valid = 1.
- dwell_orbits = 0 with mask = 0x0011 → switch on every orbitSync: 0,4,0,4.
